// File: rtl/usb_tx_encoder_if.sv
// usb_tx_encoder_if: TX read port between the packet encoder and the shared data buffer
//   buffer_occupancy   : bytes currently held in the buffer (buffer -> encoder)
//   tx_packet_data     : byte returned the cycle after a request (buffer -> encoder)
//   get_tx_packet_data : one-cycle byte request pulse (encoder -> buffer)
interface usb_tx_encoder_if;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    modport master (output get_tx_packet_data, input buffer_occupancy, input tx_packet_data);
    modport slave  (input get_tx_packet_data, output buffer_occupancy, output tx_packet_data);
endinterface

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed packet transmitter (SYNC, PID, payload, CRC16, bit stuffing, NRZI, EOP)
//   clk, n_rst          : clock, asynchronous active-low reset
//   tx_packet           : request code sampled in IDLE (1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL)
//   bus                 : data buffer TX read port (occupancy, byte, request pulse)
//   tx_transfer_active  : high while a packet is on the wire
//   dplus_out/dminus_out: registered line drive, J = (1,0) when idle
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       tx_packet,
    usb_tx_encoder_if.master bus,
    output logic             tx_transfer_active,
    output logic             dplus_out,
    output logic             dminus_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [3:0] {IDLE, SYNC, PID, LOAD, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J} state_t;
    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_active, w_active, r_get, w_get, r_dp, w_dp, r_dm, w_dm, r_j, w_j, r_data, w_data;
    logic [7:0]    r_shift, w_shift, r_pid, w_pid, w_pid_sel;
    logic [3:0]    r_left, w_left;
    logic [2:0]    r_ones, w_ones;
    logic [15:0]   r_crc, w_crc, w_crc_upd, w_crc_nx;
    logic          w_tick, w_stuff, w_last, w_more, w_accept, w_hs_end;
    logic          w_emit, w_val, w_se0, w_drive_j;
    assign w_tick    = r_active && (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_stuff   = r_ones == 3'd6;
    assign w_last    = r_left == 4'd1;
    assign w_more    = bus.buffer_occupancy != 7'd0;
    assign w_accept  = (tx_packet != 3'd0) && (tx_packet <= 3'd5);
    assign w_hs_end  = (r_state == PID) && !r_data;
    assign w_pid_sel = (tx_packet == 3'd1) ? 8'hC3 :
                       (tx_packet == 3'd2) ? 8'h4B :
                       (tx_packet == 3'd3) ? 8'hD2 :
                       (tx_packet == 3'd4) ? 8'h5A : 8'h1E;
    // Reflected CRC16 (0xA001 == bit-reversed 0x8005) so r_crc[0] is the first bit on the wire
    assign w_crc_upd = {1'b0, r_crc[15:1]} ^ ((r_shift[0] ^ r_crc[0]) ? 16'hA001 : 16'h0000);
    assign w_crc_nx  = (r_state == DATA) ? w_crc_upd : r_crc;
    assign tx_transfer_active     = r_active;
    assign dplus_out              = r_dp;
    assign dminus_out             = r_dm;
    assign bus.get_tx_packet_data = r_get;
    // Byte states describe where the NEXT bit comes from; the last bit of a byte is emitted
    // while already moving on, so a LOAD fetch overlaps that bit and no gap bit time appears.
    always_comb begin
        w_state   = r_state;
        w_cnt     = (r_active && !w_tick) ? r_cnt + 1'b1 : '0;
        w_active  = r_active;
        w_get     = 1'b0;
        w_dp      = r_dp;
        w_dm      = r_dm;
        w_j       = r_j;
        w_data    = r_data;
        w_shift   = r_shift;
        w_pid     = r_pid;
        w_left    = r_left;
        w_ones    = r_ones;
        w_crc     = r_crc;
        w_emit    = 1'b0;
        w_val     = 1'b0;
        w_se0     = 1'b0;
        w_drive_j = 1'b0;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state  = SYNC;
                w_active = 1'b1;
                w_emit   = 1'b1;
                w_shift  = 8'h40;
                w_left   = 4'd7;
                w_crc    = 16'hFFFF;
                w_data   = tx_packet <= 3'd2;
                w_pid    = w_pid_sel;
            end
            SYNC, PID, DATA, CRC_LO, CRC_HI: if (w_tick) begin
                w_emit = 1'b1;
                if (!w_stuff) begin
                    w_val   = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_left  = r_left - 4'd1;
                    w_crc   = w_crc_nx;
                    if (w_last) begin
                        w_left = 4'd8;
                        case (r_state)
                            SYNC: begin
                                w_state = PID;
                                w_shift = r_pid;
                            end
                            CRC_LO: begin
                                w_state = CRC_HI;
                                w_shift = ~r_crc[15:8];
                            end
                            CRC_HI: begin
                                w_state = EOP_SE0;
                                w_left  = 4'd2;
                            end
                            default: begin
                                w_state = w_hs_end ? EOP_SE0 : w_more ? LOAD : CRC_LO;
                                w_left  = w_hs_end ? 4'd2 : 4'd8;
                                w_get   = !w_hs_end && w_more;
                                w_shift = ~w_crc_nx[7:0];
                            end
                        endcase
                    end
                end
            end
            // First LOAD cycle carries the request pulse; the byte is latched on the next edge
            LOAD: if (!r_get) begin
                w_shift = bus.tx_packet_data;
                w_left  = 4'd8;
                w_state = DATA;
            end
            // A stuff bit still owed after the last CRC bit goes out before SE0
            EOP_SE0: if (w_tick) begin
                if (w_stuff) begin
                    w_emit = 1'b1;
                end else if (r_left != 4'd0) begin
                    w_se0  = 1'b1;
                    w_left = r_left - 4'd1;
                end else begin
                    w_drive_j = 1'b1;
                    w_state   = EOP_J;
                end
            end
            EOP_J: if (w_tick) begin
                w_state  = IDLE;
                w_active = 1'b0;
            end
            default: w_state = IDLE;
        endcase
        if (w_emit) begin
            w_j    = w_val ? r_j : ~r_j;
            w_ones = w_val ? r_ones + 3'd1 : 3'd0;
            w_dp   = w_j;
            w_dm   = ~w_j;
        end
        if (w_se0) begin
            w_dp   = 1'b0;
            w_dm   = 1'b0;
            w_ones = 3'd0;
        end
        if (w_drive_j) begin
            w_j  = 1'b1;
            w_dp = 1'b1;
            w_dm = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_get    <= 1'b0;
            r_dp     <= 1'b1;
            r_dm     <= 1'b0;
            r_j      <= 1'b1;
            r_data   <= 1'b0;
            r_shift  <= '0;
            r_pid    <= '0;
            r_left   <= '0;
            r_ones   <= '0;
            r_crc    <= 16'hFFFF;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_active <= w_active;
            r_get    <= w_get;
            r_dp     <= w_dp;
            r_dm     <= w_dm;
            r_j      <= w_j;
            r_data   <= w_data;
            r_shift  <= w_shift;
            r_pid    <= w_pid;
            r_left   <= w_left;
            r_ones   <= w_ones;
            r_crc    <= w_crc;
        end
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed self-checking bench for usb_tx_encoder with a line decoder and buffer model
module tb_usb_tx_encoder;
    localparam int CPB = 8;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] tx_packet = 3'd0;
    logic       tx_transfer_active, dplus_out, dminus_out;
    usb_tx_encoder_if bif();
    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .bus(bif),
        .tx_transfer_active(tx_transfer_active), .dplus_out(dplus_out), .dminus_out(dminus_out)
    );
    always #5 clk = ~clk;
    logic [7:0] mem [0:63];
    logic [7:0] pay [0:7];
    int         get_t [0:63];
    int         n_got = 0, n_loaded = 0, cyc = 0, act_cnt = 0, bad_get = 0;
    logic       prev_get = 1'b0;
    int         n_tests = 0, n_fail = 0;
    logic       dec[$], raw[$], ex[$];
    int         nsamp, nse0, act, ex_raw, nbad_stuff, g0, g1, d;
    logic       done;
    logic [15:0] v16;
    logic [8:0]  v9;
    assign bif.buffer_occupancy = 7'(n_loaded - n_got);
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_get <= bif.get_tx_packet_data;
        if (tx_transfer_active) act_cnt <= act_cnt + 1;
        if (bif.get_tx_packet_data && n_got < 64) begin
            bif.tx_packet_data <= mem[n_got];
            get_t[n_got]       <= cyc;
            n_got              <= n_got + 1;
            if (prev_get) bad_get <= bad_get + 1;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic load(input int nb);
        for (int i = 0; i < nb; i++) mem[n_got + i] = pay[i];
        n_loaded = n_got + nb;
    endtask
    task automatic build(input logic [7:0] pid, input int nb, input logic dat);
        logic [15:0] c;
        logic        b, fb;
        int          ones;
        ex.delete();
        for (int i = 0; i < 7; i++) ex.push_back(1'b0);
        ex.push_back(1'b1);
        for (int i = 0; i < 8; i++) ex.push_back(pid[i]);
        c = 16'hFFFF;
        for (int j = 0; j < nb; j++)
            for (int i = 0; i < 8; i++) begin
                b  = pay[j][i];
                ex.push_back(b);
                fb = b ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        if (dat) for (int i = 0; i < 16; i++) ex.push_back(~c[15 - i]);
        ex_raw = 3;
        ones   = 0;
        foreach (ex[i]) begin
            ex_raw++;
            ones = ex[i] ? ones + 1 : 0;
            if (ones == 6) begin
                ex_raw++;
                ones = 0;
            end
        end
    endtask
    task automatic capture(input logic [2:0] code);
        logic pj, cj;
        int   ones, a0;
        dec.delete();
        raw.delete();
        nsamp = 0;
        nse0 = 0;
        nbad_stuff = 0;
        done = 1'b0;
        ones = 0;
        pj = 1'b1;
        @(negedge clk);
        a0 = act_cnt;
        tx_packet = code;
        @(negedge clk);
        tx_packet = 3'd0;
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 400 && !done; k++) begin
            nsamp++;
            if (!dplus_out && !dminus_out) nse0++;
            else if (nse0 != 0) done = 1'b1;
            else begin
                cj = dplus_out;
                raw.push_back(cj == pj);
                if (ones == 6) begin
                    if (cj == pj) nbad_stuff++;
                    ones = 0;
                end else begin
                    dec.push_back(cj == pj);
                    ones = (cj == pj) ? ones + 1 : 0;
                end
                pj = cj;
            end
            if (!done) repeat (CPB) @(negedge clk);
        end
        for (int k = 0; k < 4 * CPB && tx_transfer_active; k++) @(negedge clk);
        act = act_cnt - a0;
        chk("capture_done", done, 1);
        chk("end_active_low", tx_transfer_active, 0);
        chk("end_line_j", {dplus_out, dminus_out}, 2'b10);
        chk("stuff_bits_zero", nbad_stuff, 0);
    endtask
    task automatic cmp_stream(input string tag);
        int bad;
        bad = 0;
        if (dec.size() == ex.size()) foreach (ex[i]) if (dec[i] !== ex[i]) bad++;
        chk({tag, "_len"}, dec.size(), ex.size());
        chk({tag, "_bits"}, bad, 0);
    endtask
    function automatic logic [15:0] resid();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 16; i < dec.size(); i++) c = {c[14:0], 1'b0} ^ ((dec[i] ^ c[15]) ? 16'h8005 : 16'h0000);
        return c;
    endfunction
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dplus", dplus_out, 1);
        chk("rst_dminus", dminus_out, 0);
        chk("rst_active", tx_transfer_active, 0);
        chk("rst_get", bif.get_tx_packet_data, 0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        g0 = n_got;
        build(8'hD2, 0, 1'b0);
        capture(3'd3);
        cmp_stream("ack");
        chk("ack_bit_times", nsamp, 19);
        chk("ack_se0", nse0, 2);
        chk("ack_active_cycles", act, 19 * CPB);
        chk("ack_gets", n_got - g0, 0);
        g0 = n_got;
        build(8'hC3, 0, 1'b1);
        capture(3'd1);
        cmp_stream("zlp");
        v16 = '1;
        if (dec.size() >= 32) for (int i = 0; i < 16; i++) v16[i] = dec[16 + i];
        chk("zlp_crc", v16, 16'h0000);
        chk("zlp_resid", resid(), 16'h800D);
        chk("zlp_gets", n_got - g0, 0);
        chk("zlp_bit_times", nsamp, ex_raw);
        pay[0] = 8'hFF;
        load(1);
        g0 = n_got;
        build(8'h4B, 1, 1'b1);
        capture(3'd2);
        cmp_stream("d1ff");
        v9 = '0;
        if (raw.size() >= 25) for (int i = 0; i < 9; i++) v9[8 - i] = raw[16 + i];
        chk("d1ff_stuff_pattern", v9, 9'b111111011);
        chk("d1ff_resid", resid(), 16'h800D);
        chk("d1ff_gets", n_got - g0, 1);
        chk("d1ff_bit_times", nsamp, ex_raw);
        for (int i = 0; i < 4; i++) pay[i] = 8'(i);
        load(4);
        g0 = n_got;
        build(8'hC3, 4, 1'b1);
        capture(3'd1);
        cmp_stream("d0x4");
        chk("d0x4_gets", n_got - g0, 4);
        for (int k = 1; k < 4; k++) begin
            d = get_t[g0 + k] - get_t[g0 + k - 1];
            chk("d0x4_get_gap", (d == 8 * CPB) || (d == 9 * CPB), 1);
        end
        chk("d0x4_resid", resid(), 16'h800D);
        chk("d0x4_bit_times", nsamp, ex_raw);
        chk("get_pulse_width", bad_get, 0);
        pay[0] = 8'hA5;
        pay[1] = 8'h5A;
        pay[2] = 8'h3C;
        load(3);
        g0 = n_got;
        @(negedge clk);
        tx_packet = 3'd1;
        @(negedge clk);
        tx_packet = 3'd0;
        for (int k = 0; k < 100 * CPB && n_got == g0; k++) @(negedge clk);
        chk("mid_first_get", n_got != g0, 1);
        repeat (3 * CPB) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_dplus", dplus_out, 1);
        chk("mid_rst_dminus", dminus_out, 0);
        chk("mid_rst_active", tx_transfer_active, 0);
        @(negedge clk);
        n_rst = 1'b1;
        g1 = n_got;
        repeat (30 * CPB) @(negedge clk);
        chk("mid_rst_no_gets", n_got - g1, 0);
        chk("mid_rst_idle", tx_transfer_active, 0);
        n_loaded = n_got;
        build(8'hD2, 0, 1'b0);
        capture(3'd3);
        cmp_stream("ack_after_rst");
        chk("ack_after_rst_active", act, 19 * CPB);
        fork
            capture(3'd3);
            begin
                repeat (6 * CPB) @(negedge clk);
                tx_packet = 3'd4;
                repeat (2 * CPB) @(negedge clk);
                tx_packet = 3'd0;
            end
        join
        cmp_stream("ack_ignore");
        chk("ack_ignore_bit_times", nsamp, 19);
        repeat (5) @(negedge clk);
        chk("ignored_no_restart", tx_transfer_active, 0);
        build(8'h5A, 0, 1'b0);
        capture(3'd4);
        cmp_stream("nak");
        chk("nak_active_cycles", act, 19 * CPB);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
- USB full-speed packet transmitter on the host-facing end of the USB-AHB module.
- Draws payload bytes out of the shared data buffer via the buffer's TX read port (get_tx_packet_data / tx_packet_data).
- Serialises SYNC, PID, payload and CRC16, then applies bit stuffing and NRZI and drives D+/D-, ending each packet with EOP.
- Started by the protocol controller; reports activity back to it.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time (bit_tick period); must be >= 4

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
tx_packet  input  3  packet request code, sampled in IDLE: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 ignored
buffer_occupancy  input  7  bytes currently held in data buffer
tx_packet_data  input  8  byte from data buffer, valid the cycle after get_tx_packet_data
get_tx_packet_data  output  1  one-cycle byte request pulse to data buffer
tx_transfer_active  output  1  high while a packet is being sent
dplus_out  output  1  D+ line drive
dminus_out  output  1  D- line drive

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk. Reset values: dplus_out=1, dminus_out=0 (J/idle), get_tx_packet_data=0, tx_transfer_active=0. State returns to IDLE and all counters clear. Reset mid-packet aborts at once with lines back at J and no EOP.
- Bit timer: free-running only while tx_transfer_active. bit_tick asserts on count CLKS_PER_BIT-1. First bit is driven on the cycle after acceptance.
- States: IDLE, SYNC, PID, LOAD, DATA, CRC_LO, CRC_HI, EOP_SE0 (2 bit times), EOP_J (1 bit time).
- IDLE: a code of 1-5 is accepted → SYNC, and tx_transfer_active rises on the next edge. Codes 0/6/7 leave the block in IDLE. Requests that arrive while active are ignored.
- SYNC: 8 bits 00000001, in time order. → PID.
- PID byte: DATA0=0xC3, DATA1=0x4B, ACK=0xD2, NAK=0x5A, STALL=0x1E.
- Bit order: every byte goes out LSB first.
- After PID: handshake codes → EOP_SE0. Data codes → LOAD if buffer_occupancy != 0, else CRC_LO (zero-length packet).
- LOAD: pulse get_tx_packet_data for exactly 1 cycle. Latch tx_packet_data on the following edge into the shift register. → DATA. The latch completes before the next bit_tick.
- DATA: shift 8 bits. On the last bit's tick, buffer_occupancy is sampled: nonzero → LOAD, zero → CRC_LO. No gap bit time between consecutive bytes.
- CRC16: poly x^16+x^15+x^2+1, init 0xFFFF. Computed over payload bits only (pre-stuffing), one update per data bit. Transmitted value is the ones-complement of the remainder, low byte first (CRC_LO), LSB first, then CRC_HI.
- Bit stuffing: applies from the first SYNC bit through the last CRC bit. A count of consecutive 1 bits (pre-NRZI) is kept; after the 6th consecutive 1, a 0 bit is inserted for one bit time. The data shift stalls during the stuffed bit, and the count resets on every 0, including stuffed ones. A stuff bit owed after the final CRC bit is still sent before EOP.
- NRZI: a 0 toggles the line state (J↔K), a 1 holds it. J = (1,0), K = (0,1). The line state starts at J at SYNC.
- EOP_SE0: dplus_out=dminus_out=0 for 2 bit times. EOP_J: J for 1 bit time. Then → IDLE and tx_transfer_active falls, lines at J.
- Buffer emptying: buffer_occupancy is only consulted at byte boundaries. The block never requests a byte when occupancy is 0. Max payload is bounded by the buffer (64 bytes).
- Outputs are registered; no combinational path from inputs to dplus_out/dminus_out.

Test Plan:
- Reset mid-DATA byte with n_rst low for 1 cycle → lines immediately (1,0), tx_transfer_active=0, no get pulses afterward. A fresh ACK request is then sent correctly.
- ACK request (tx_packet=3), occupancy 0 → decoded stream 00000001 01001011, then SE0 2 bit times, then J. tx_transfer_active is high for exactly 19*CLKS_PER_BIT cycles (+1 acceptance cycle); zero get pulses.
- DATA0 with occupancy 0 (ZLP) → SYNC, PID bits 11000011, CRC 0x0000 as 16 zeros, EOP. CRC bits NRZI-toggle every bit time.
- DATA1 with 1 byte 0xFF → PID bits 11010010, then 111111 0 11 (stuff after sixth 1). Exactly 1 get pulse. Receiver-side CRC over payload+CRC yields residual 0x800D.
- DATA0 with 4 bytes 0x00,0x01,0x02,0x03 (occupancy decrementing 4→0 per get) → exactly 4 get pulses, each 8 or 9 bit times apart. Payload bytes match. CRC residual check 0x800D. Total bit count matches the reference model.
- Second tx_packet=4 asserted while active → ignored; the first packet completes unchanged. NAK is accepted when asserted in IDLE afterward.
